alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Parametrised, registered ALU with valid/ready handshake on input and output.
//  Extends the 8-op combinational ALU to 16 ops: shifts, set-less-than, and
//  carry-chained add/sub backed by an architectural carry flag.
//  Sits between the operand-issue logic and the writeback/consumer stage.
//  A one-entry output register gives 1-cycle latency with full-throughput backpressure.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; must be a power of 2 and >= 8.
//  TAG_W  4   width of the opaque tag that travels alongside each operation.
// PORTS
//  clk         in   1          rising-edge clock.
//  rst_n       in   1          synchronous, active-low reset.
//  in_valid    in   1          an operation is offered.
//  in_ready    out  1          the block can accept the offered operation.
//  in_a        in   WIDTH      operand A.
//  in_b        in   WIDTH      operand B; B[log2(WIDTH)-1:0] is the shift amount.
//  in_op       in   4          opcode; see BEHAVIOUR.
//  in_tag      in   TAG_W      tag, returned unchanged with the result.
//  out_valid   out  1          out_* fields hold a result.
//  out_ready   in   1          the consumer accepts the result.
//  out_result  out  WIDTH      result value.
//  out_tag     out  TAG_W      tag of this result.
//  out_zero    out  1          out_result == 0.
//  out_carry   out  1          carry/borrow of this op; 0 for non-arithmetic ops.
//  out_ovf     out  1          signed overflow of this op; 0 for non-arithmetic ops.
//  carry_flag  out  1          architectural carry flag; used by ADDC/SUBB.
//  sticky_ovf  out  1          set by any accepted op that overflows.
//  clr_sticky  in   1          clears sticky_ovf.
// BEHAVIOUR
//  Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NAND, 6 NOT A, 7 PASS A,
//    8 SLL, 9 SRL, 10 SRA, 11 SLT (signed), 12 SLTU, 13 ADDC, 14 SUBB, 15 PASS B.
//  Accept: a transfer occurs when in_valid && in_ready.
//    in_ready = !out_valid || out_ready (combinational).
//  Latency: an accepted op appears on out_* on the next cycle, with out_valid=1.
//    out_* hold stable while out_valid && !out_ready.
//    out_valid clears after an output handshake when no new op is accepted that cycle.
//    Simultaneous output handshake and input accept: the new result replaces the old.
//    Throughput is 1 op/cycle.
//  Arithmetic: computed at WIDTH+1 bits.
//    ADD:  carry = bit WIDTH of A+B.
//    SUB:  carry = borrow, i.e. bit WIDTH of A-B; 1 when A<B unsigned.
//    ADDC: A+B+carry_flag.
//    SUBB: A-B-carry_flag.
//    Overflow, add-type: A[msb]==B[msb] && R[msb]!=A[msb].
//    Overflow, sub-type: A[msb]!=B[msb] && R[msb]!=A[msb].
//  Shifts: amount is B mod WIDTH. SRA replicates A[msb]. carry=ovf=0.
//  SLT/SLTU: result is {WIDTH-1 zeros, lt}. carry=ovf=0.
//  carry_flag: on accept of op 0/1/13/14, updates to that op's carry on the same
//    edge as out_* load. Other ops leave it unchanged.
//    Back-to-back ADD then ADDC chains correctly with no stall.
//  sticky_ovf: set on accept of an op with ovf=1. Cleared by clr_sticky.
//    If set and clear occur in the same cycle, set wins.
//  Reset (rst_n=0 at a clock edge): out_valid=0, out_result=0, out_tag=0,
//    out_zero=0, out_carry=0, out_ovf=0, carry_flag=0, sticky_ovf=0.
//    in_ready reads 1 on the first cycle after reset.
//    Reset mid-operation discards any held result; no handshake completes in a reset cycle.
// TESTING  (WIDTH=32)
//  ADD 0xFFFFFFFF+1, tag 5 -> next cycle: result 0, zero=1, carry=1, ovf=0,
//    tag 5, carry_flag=1.
//  Chain ADD 0xFFFFFFFF+2 then ADDC 0+0 back-to-back -> results 1, then 1;
//    carry_flag ends at 0.
//  SUB 0x80000000-1 -> result 0x7FFFFFFF, ovf=1, sticky_ovf=1.
//    Then clr_sticky and an overflowing ADD in the same cycle -> sticky stays 1.
//  SRA 0x80000000 by B=33 -> 0xC0000000.
//    SLT 0xFFFFFFFF,1 -> 1. SLTU 0xFFFFFFFF,1 -> 0.
//  Hold out_ready=0 with 3 ops offered -> 1 accepted, in_ready=0, out_* stable.
//    Release -> remaining ops complete at 1 op/cycle, in order, tags intact.
//  Assert rst_n=0 while out_valid=1 and stalled -> out_valid=0 and all flags 0
//    next cycle; no output handshake occurs.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: 16-op registered ALU with valid/ready handshake on both sides.
//   A single output register gives 1-cycle latency. It can reload in the same
//   cycle that the consumer takes the old result, so throughput is 1 op/cycle.
//   The architectural carry flag feeds ADDC/SUBB. A sticky overflow flag
//   records any overflow until software clears it.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   in_valid/in_ready           input handshake
//   in_a, in_b, in_op, in_tag   operands, opcode, opaque tag
//   out_valid/out_ready         output handshake
//   out_result, out_tag         result and its tag
//   out_zero/carry/ovf          per-result flags
//   carry_flag, sticky_ovf      architectural flags; clr_sticky clears sticky
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             carry_flag,
  output logic             sticky_ovf,
  input  logic             clr_sticky
);
  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3,
    OP_XOR  = 4'd4,  OP_NAND = 4'd5,  OP_NOTA = 4'd6,  OP_PASA = 4'd7,
    OP_SLL  = 4'd8,  OP_SRL  = 4'd9,  OP_SRA  = 4'd10, OP_SLT  = 4'd11,
    OP_SLTU = 4'd12, OP_ADDC = 4'd13, OP_SUBB = 4'd14, OP_PASB = 4'd15
  } op_e;

  op_e              op;
  logic             accept;
  logic             cin;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   add_w, sub_w;
  logic             add_ovf, sub_ovf;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             zero_q, zero_d;
  logic             c_q, c_d;
  logic             v_q, v_d;
  logic             cf_q, cf_d;
  logic             sticky_q, sticky_d;

  assign op       = op_e'(in_op);
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign shamt    = in_b[SHW-1:0];

  // Carry-in uses the flag as it stands now. The flag is written on the same
  // edge the result loads, so an ADDC right behind an ADD sees the new carry.
  assign cin   = cf_q && (op == OP_ADDC || op == OP_SUBB);
  assign add_w = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, cin};
  // Bit WIDTH of the extended difference is the borrow.
  assign sub_w = {1'b0, in_a} - {1'b0, in_b} - {{WIDTH{1'b0}}, cin};
  assign add_ovf = (in_a[MSB] == in_b[MSB]) && (add_w[MSB] != in_a[MSB]);
  assign sub_ovf = (in_a[MSB] != in_b[MSB]) && (sub_w[MSB] != in_a[MSB]);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD, OP_ADDC: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = add_ovf;
      end
      OP_SUB, OP_SUBB: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = sub_w[WIDTH];
        alu_v   = sub_ovf;
      end
      OP_AND:  alu_res = in_a & in_b;
      OP_OR:   alu_res = in_a | in_b;
      OP_XOR:  alu_res = in_a ^ in_b;
      OP_NAND: alu_res = ~(in_a & in_b);
      OP_NOTA: alu_res = ~in_a;
      OP_PASA: alu_res = in_a;
      OP_SLL:  alu_res = in_a << shamt;
      OP_SRL:  alu_res = in_a >> shamt;
      OP_SRA:  alu_res = WIDTH'($signed(in_a) >>> shamt);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
      OP_PASB: alu_res = in_b;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    valid_d  = valid_q;
    res_d    = res_q;
    tag_d    = tag_q;
    zero_d   = zero_q;
    c_d      = c_q;
    v_d      = v_q;
    cf_d     = cf_q;
    sticky_d = sticky_q;
    if (accept) begin
      // A new op overwrites whatever was held; the old one is either being
      // taken this cycle or the register was empty.
      valid_d = 1'b1;
      res_d   = alu_res;
      tag_d   = in_tag;
      zero_d  = (alu_res == '0);
      c_d     = alu_c;
      v_d     = alu_v;
      if (op == OP_ADD || op == OP_SUB || op == OP_ADDC || op == OP_SUBB)
        cf_d = alu_c;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
    // Set takes priority over clear.
    if (accept && alu_v)  sticky_d = 1'b1;
    else if (clr_sticky)  sticky_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      res_q    <= '0;
      tag_q    <= '0;
      zero_q   <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      cf_q     <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      res_q    <= res_d;
      tag_q    <= tag_d;
      zero_q   <= zero_d;
      c_q      <= c_d;
      v_q      <= v_d;
      cf_q     <= cf_d;
      sticky_q <= sticky_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_result = res_q;
  assign out_tag    = tag_q;
  assign out_zero   = zero_q;
  assign out_carry  = c_q;
  assign out_ovf    = v_q;
  assign carry_flag = cf_q;
  assign sticky_ovf = sticky_q;
endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;
  localparam int W = 32;
  localparam int T = 4;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_a, in_b, out_result;
  logic [3:0]   in_op;
  logic [T-1:0] in_tag, out_tag;
  logic         out_zero, out_carry, out_ovf, carry_flag, sticky_ovf, clr_sticky;

  int tests = 0;
  int fails = 0;

  alu_pipe #(.WIDTH(W), .TAG_W(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag),
    .out_zero(out_zero), .out_carry(out_carry), .out_ovf(out_ovf),
    .carry_flag(carry_flag), .sticky_ovf(sticky_ovf), .clr_sticky(clr_sticky)
  );

  always #5 clk = ~clk;

  // Packed view of every observable output: valid,result,tag,zero,c,v,cf,sticky
  logic [W+T+5:0] obs;
  assign obs = {out_valid, out_result, out_tag, out_zero, out_carry, out_ovf,
                carry_flag, sticky_ovf};

  // Advance one clock; inputs are changed and outputs sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [T-1:0] tag);
    in_valid = v; in_op = op; in_a = a; in_b = b; in_tag = tag;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
    drive(1'b1, 4'd0, 32'h8000_0000, 32'h8000_0000, 4'd9);
    step(); step();
    tests++;
    if (obs !== '0) begin
      fails++; $display("FAIL reset_state: got %h want 0", obs);
    end
    drive(1'b0, 4'd0, '0, '0, '0);
    rst_n = 1'b1;
    step();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_ready: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_add_wrap();
    drive(1'b1, 4'd0, 32'hFFFF_FFFF, 32'h1, 4'd5);
    step();
    drive(1'b0, 4'd0, '0, '0, '0);
    tests++;
    if (obs !== {1'b1, 32'h0, 4'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      fails++; $display("FAIL add_wrap: got %h", obs);
    end
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL drain_after_handshake: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_chain();
    drive(1'b1, 4'd0, 32'hFFFF_FFFF, 32'h2, 4'd1);
    step();
    tests++;
    if ({out_result, out_carry, carry_flag} !== {32'h1, 1'b1, 1'b1}) begin
      fails++; $display("FAIL chain_add: res=%h c=%b cf=%b want 1/1/1", out_result, out_carry, carry_flag);
    end
    drive(1'b1, 4'd13, 32'h0, 32'h0, 4'd2);
    step();
    drive(1'b0, 4'd0, '0, '0, '0);
    tests++;
    if ({out_valid, out_result, out_tag, out_carry, carry_flag} !== {1'b1, 32'h1, 4'd2, 1'b0, 1'b0}) begin
      fails++; $display("FAIL chain_addc: res=%h tag=%0d c=%b cf=%b want 1/2/0/0", out_result, out_tag, out_carry, carry_flag);
    end
    step();
  endtask

  task automatic test_ovf_sticky();
    drive(1'b1, 4'd1, 32'h8000_0000, 32'h1, 4'd3);
    step();
    tests++;
    if ({out_result, out_ovf, out_carry, sticky_ovf} !== {32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1}) begin
      fails++; $display("FAIL sub_ovf: res=%h v=%b c=%b sticky=%b want 7fffffff/1/0/1", out_result, out_ovf, out_carry, sticky_ovf);
    end
    clr_sticky = 1'b1;
    drive(1'b1, 4'd0, 32'h7FFF_FFFF, 32'h1, 4'd4);
    step();
    drive(1'b0, 4'd0, '0, '0, '0);
    tests++;
    if ({out_result, out_ovf, sticky_ovf} !== {32'h8000_0000, 1'b1, 1'b1}) begin
      fails++; $display("FAIL set_beats_clear: res=%h v=%b sticky=%b want 80000000/1/1", out_result, out_ovf, sticky_ovf);
    end
    step();
    clr_sticky = 1'b0;
    tests++;
    if (sticky_ovf !== 1'b0) begin
      fails++; $display("FAIL sticky_clear: sticky=%b want 0", sticky_ovf);
    end
  endtask

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b, res;
    logic         c, v;
  } vec_t;

  // Issued back-to-back with out_ready=1; one result checked per cycle.
  task automatic test_ops();
    vec_t vt[$];
    logic exp_cf;
    vt.push_back('{4'd2,  32'hF0F0_1234, 32'h0FF0_0021, 32'h00F0_0020, 1'b0, 1'b0});
    vt.push_back('{4'd3,  32'hF0F0_1234, 32'h0FF0_0021, 32'hFFF0_1235, 1'b0, 1'b0});
    vt.push_back('{4'd4,  32'hF0F0_1234, 32'h0FF0_0021, 32'hFF00_1215, 1'b0, 1'b0});
    vt.push_back('{4'd5,  32'hF0F0_1234, 32'h0FF0_0021, 32'hFF0F_FFDF, 1'b0, 1'b0});
    vt.push_back('{4'd6,  32'hF0F0_1234, 32'h0FF0_0021, 32'h0F0F_EDCB, 1'b0, 1'b0});
    vt.push_back('{4'd7,  32'hF0F0_1234, 32'h0FF0_0021, 32'hF0F0_1234, 1'b0, 1'b0});
    vt.push_back('{4'd15, 32'hF0F0_1234, 32'h0FF0_0021, 32'h0FF0_0021, 1'b0, 1'b0});
    vt.push_back('{4'd8,  32'hF0F0_1234, 32'h0FF0_0021, 32'hE1E0_2468, 1'b0, 1'b0});
    vt.push_back('{4'd9,  32'hF0F0_1234, 32'h0FF0_0021, 32'h7878_091A, 1'b0, 1'b0});
    vt.push_back('{4'd10, 32'hF0F0_1234, 32'h0FF0_0021, 32'hF878_091A, 1'b0, 1'b0});
    vt.push_back('{4'd10, 32'h8000_0000, 32'd33,        32'hC000_0000, 1'b0, 1'b0});
    vt.push_back('{4'd11, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1'b0});
    vt.push_back('{4'd12, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1'b0});
    vt.push_back('{4'd1,  32'h1,         32'h2,         32'hFFFF_FFFF, 1'b1, 1'b0});
    vt.push_back('{4'd2,  32'h0,         32'h0,         32'h0,         1'b0, 1'b0});
    vt.push_back('{4'd14, 32'h5,         32'h2,         32'h2,         1'b0, 1'b0});
    vt.push_back('{4'd13, 32'h3,         32'h4,         32'h7,         1'b0, 1'b0});
    vt.push_back('{4'd8,  32'h1,         32'd31,        32'h8000_0000, 1'b0, 1'b0});
    exp_cf = carry_flag;
    for (int i = 0; i < vt.size(); i++) begin
      drive(1'b1, vt[i].op, vt[i].a, vt[i].b, T'(i));
      step();
      if (vt[i].op inside {4'd0, 4'd1, 4'd13, 4'd14}) exp_cf = vt[i].c;
      tests++;
      if (obs !== {1'b1, vt[i].res, T'(i), (vt[i].res == '0), vt[i].c, vt[i].v, exp_cf, 1'b0}) begin
        fails++;
        $display("FAIL op_vec%0d op=%0d: got res=%h tag=%0d z=%b c=%b v=%b cf=%b, want res=%h c=%b v=%b cf=%b",
                 i, vt[i].op, out_result, out_tag, out_zero, out_carry, out_ovf, carry_flag,
                 vt[i].res, vt[i].c, vt[i].v, exp_cf);
      end
    end
    drive(1'b0, 4'd0, '0, '0, '0);
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 4'd15, '0, 32'h11, 4'd1);
    step();
    drive(1'b1, 4'd15, '0, 32'h22, 4'd2);
    for (int k = 0; k < 3; k++) begin
      tests++;
      if ({out_valid, out_result, out_tag, in_ready} !== {1'b1, 32'h11, 4'd1, 1'b0}) begin
        fails++; $display("FAIL stall_hold%0d: v=%b res=%h tag=%0d in_ready=%b want 1/11/1/0", k, out_valid, out_result, out_tag, in_ready);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL ready_comb: in_ready=%b want 1", in_ready);
    end
    step();
    drive(1'b1, 4'd15, '0, 32'h33, 4'd3);
    tests++;
    if ({out_valid, out_result, out_tag} !== {1'b1, 32'h22, 4'd2}) begin
      fails++; $display("FAIL release_op2: res=%h tag=%0d want 22/2", out_result, out_tag);
    end
    step();
    drive(1'b0, 4'd0, '0, '0, '0);
    tests++;
    if ({out_valid, out_result, out_tag} !== {1'b1, 32'h33, 4'd3}) begin
      fails++; $display("FAIL release_op3: res=%h tag=%0d want 33/3", out_result, out_tag);
    end
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL release_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(1'b1, 4'd0, 32'h8000_0000, 32'h8000_0000, 4'd7);
    step();
    drive(1'b0, 4'd0, '0, '0, '0);
    tests++;
    if (obs !== {1'b1, 32'h0, 4'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}) begin
      fails++; $display("FAIL pre_reset_load: got %h", obs);
    end
    rst_n = 1'b0;
    step();
    tests++;
    if (obs !== '0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_mid: got %h in_ready=%b want 0/1", obs, in_ready);
    end
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
    drive(1'b0, 4'd0, '0, '0, '0);
    test_reset();
    test_add_wrap();
    test_chain();
    test_ovf_sticky();
    test_ops();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
